csi2_pkt_handler: RTL and testbench
===================================

// Module: csi2_pkt_handler
// PURPOSE
// - Sits directly downstream of the CSI-2 header ECC decoder and consumes its ECC-checked word stream.
// - Parses each packet header: DI is [7:0] (VC [7:6], DT [5:0]), WC/short data is [23:8], [31:24] is ignored.
// - Splits traffic into short-packet events and a byte-qualified long-packet payload stream; strips the CRC.
// - Drives pkt_done_o back to the decoder so that it re-arms header detection for the next packet.
// PARAMETERS
// - VC_MASK   4'hF  bit v=1: packets on VC v are output; masked VCs are still consumed and complete pkt_done_o
// - PASS_CORR 1     1: headers with corrected ECC errors are processed; 0: treated as uncorrectable
// PORTS
// - clk_i             in   1   clock
// - rst_n_i           in   1   reset, synchronous, active-low
// - data_i            in   32  word from ECC decoder
// - valid_i           in   1   data_i qualifier; no backpressure, may gap mid-packet
// - error_i           in   1   header ECC error; sampled only with the header word
// - error_corrected_i in   1   header error was corrected; sampled with the header word
// - pkt_done_o        out  1   one-cycle end-of-packet strobe to the decoder
// - sp_valid_o        out  1   short-packet strobe
// - sp_vc_o           out  2   short-packet VC
// - sp_dt_o           out  6   short-packet DT (0x00..0x0F)
// - sp_data_o         out  16  short-packet data field (frame/line number)
// - lp_vc_o           out  2   current long-packet VC; held until the next header
// - lp_dt_o           out  6   current long-packet DT; held until the next header
// - lp_wc_o           out  16  current long-packet WC; held until the next header
// - tdata_o           out  32  payload word, byte 0 in [7:0]
// - tvalid_o          out  1   payload qualifier
// - tkeep_o           out  4   valid-byte mask
// - tlast_o           out  1   last payload word of the packet
// - ecc_err_o         out  1   pulse: header dropped due to ECC
// - crc_err_o         out  1   pulse: payload CRC mismatch (macro only)
// BEHAVIOUR
// - Reset (rst_n_i=0 at a clk_i edge): every output 0; state IDLE; counters 0. Mid-packet reset abandons the packet, with no tlast_o or pkt_done_o.
// - FSM states: IDLE, PAYLOAD, DONE.
// - IDLE: the first valid_i word is the header (cycle N).
//   - If error_i && (!error_corrected_i || !PASS_CORR): ecc_err_o=1 at N+1, go to DONE.
//   - Else if DT<0x10 (short packet): sp_* valid at N+1 (only when the VC is in VC_MASK), go to DONE.
//   - Else (long packet): latch lp_*; words_left = (WC+2+3)>>2, computed at 17-bit width; go to PAYLOAD.
// - PAYLOAD: each valid_i decrements words_left; input gaps hold all state.
//   - Payload word index k (0-based) is a payload word while 4k < WC. Output on tdata_o/tvalid_o one cycle after input.
//   - tkeep_o=4'hF, except on the last payload word: WC%4 = 0 -> F, 1 -> 1, 2 -> 3, 3 -> 7.
//   - tlast_o is coincident with the last payload word; it is not delayed to the CRC-only word.
//   - CRC bytes are never output. When WC%4 is 0 or 3, a trailing CRC-only word exists and produces no tvalid_o.
//   - WC=0: one CRC-only word, no tvalid_o, no tlast_o.
//   - On the valid word with words_left==1 (cycle M): go to DONE.
// - DONE: pkt_done_o=1 at M+1, which is the DONE cycle; valid_i is ignored; next state IDLE.
// - Masked VC: the FSM runs normally; tvalid_o, tlast_o and sp_valid_o stay 0.
// - lp_* registers update only on long-packet headers.
// CONFIGURATION
// - CSI2_CRC_CHECK_EN defined:
//   - CRC-16 over the WC payload bytes: polynomial x^16+x^12+x^5+1, reflected (0x8408), LSB first, seed 16'hFFFF.
//   - Up to 4 bytes are folded per cycle, gated by byte position.
//   - Received CRC: low byte is payload byte WC, high byte is WC+1; it may straddle two words when WC%4=3.
//   - On mismatch, crc_err_o=1 coincident with pkt_done_o.
// - CSI2_CRC_CHECK_EN undefined: no CRC logic; crc_err_o tied 0.
// TESTING
// - Short packet: hdr 0x00000100, err=0 -> N+1: sp_valid_o=1, dt=0x00, vc=0, data=0x0001, pkt_done_o=1.
// - RAW8, WC=6: hdr 0x0000062A + 2 words -> tkeep F, then 3 with tlast; pkt_done_o the cycle after word 2.
// - WC=4: 2 words -> word1 tkeep F with tlast; word2 produces no tvalid_o; pkt_done_o after word2.
// - WC=7 with a 3-cycle valid_i gap mid-packet -> tkeep F, 7 with tlast, CRC word dropped; counts unaffected by the gap.
// - Header with err=1, corr=0 -> ecc_err_o=1 and pkt_done_o=1 at N+1; no sp/tvalid output.
// - VC_MASK=4'h1, hdr on VC1 WC=8 -> 3 words consumed, no tvalid_o, pkt_done_o=1.
// - Macro on: correct CRC -> crc_err_o=0; flip CRC bit 0 (WC=7, straddling case) -> crc_err_o=1 with pkt_done_o.
// - Reset asserted after payload word 1 of WC=16 -> all outputs 0 next cycle; the next header is parsed normally.

Source files
------------

// File: rtl/csi2_pkt_handler_if.sv
// CSI-2 packet handler bus: ECC-decoder word stream in,
// short-packet events, payload stream and status out.
interface csi2_pkt_handler_if;
  logic [31:0] data_i;
  logic        valid_i;
  logic        error_i;
  logic        error_corrected_i;
  logic        pkt_done_o;
  logic        sp_valid_o;
  logic [1:0]  sp_vc_o;
  logic [5:0]  sp_dt_o;
  logic [15:0] sp_data_o;
  logic [1:0]  lp_vc_o;
  logic [5:0]  lp_dt_o;
  logic [15:0] lp_wc_o;
  logic [31:0] tdata_o;
  logic        tvalid_o;
  logic [3:0]  tkeep_o;
  logic        tlast_o;
  logic        ecc_err_o;
  logic        crc_err_o;

  modport slave (
    input  data_i, valid_i, error_i, error_corrected_i,
    output pkt_done_o, sp_valid_o, sp_vc_o, sp_dt_o, sp_data_o,
    output lp_vc_o, lp_dt_o, lp_wc_o,
    output tdata_o, tvalid_o, tkeep_o, tlast_o,
    output ecc_err_o, crc_err_o
  );

  modport master (
    output data_i, valid_i, error_i, error_corrected_i,
    input  pkt_done_o, sp_valid_o, sp_vc_o, sp_dt_o, sp_data_o,
    input  lp_vc_o, lp_dt_o, lp_wc_o,
    input  tdata_o, tvalid_o, tkeep_o, tlast_o,
    input  ecc_err_o, crc_err_o
  );
endinterface

// File: rtl/csi2_pkt_handler.sv
// CSI-2 packet handler: header parse, short/long split, CRC strip.
// Optional payload CRC-16 check enabled by CSI2_CRC_CHECK_EN.
module csi2_pkt_handler #(
  parameter logic [3:0] VC_MASK   = 4'hF,
  parameter bit         PASS_CORR = 1'b1
) (
  input logic               clk_i,
  input logic               rst_n_i,
  csi2_pkt_handler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PAYLOAD, DONE} state_t;

  state_t             state, state_nx;
  logic [15:0]        words_left;
  logic [16:0]        off;
  logic [15:0]        wc;
  logic               lp_en;
  logic [1:0]         hdr_vc;
  logic [5:0]         hdr_dt;
  logic [15:0]        hdr_wc;
  logic [16:0]        hdr_words;
  logic               hdr_drop;
  logic               hdr_short;
  logic               hdr_en;
  logic signed [17:0] rel;
  logic               pay;
  logic               last;
  logic [3:0]         keep;
  logic               hdr_go;
  logic               pay_go;

  assign hdr_vc    = bus.data_i[7:6];
  assign hdr_dt    = bus.data_i[5:0];
  assign hdr_wc    = bus.data_i[23:8];
  assign hdr_words = ({1'b0, hdr_wc} + 17'd5) >> 2;
  assign hdr_drop  = bus.error_i
                   && (!bus.error_corrected_i || !PASS_CORR);
  assign hdr_short = hdr_dt < 6'h10;
  assign hdr_en    = VC_MASK[hdr_vc];
  assign hdr_go    = (state == IDLE) && bus.valid_i;
  assign pay_go    = (state == PAYLOAD) && bus.valid_i;

  // bytes of payload still ahead of this word; <=0 means CRC/pad only
  assign rel  = $signed({2'b00, wc}) - $signed({1'b0, off});
  assign pay  = rel > 18'sd0;
  assign last = pay && (rel <= 18'sd4);

  always_comb begin
    keep = 4'h1;
    unique case (1'b1)
      rel >= 18'sd4: keep = 4'hF;
      rel == 18'sd3: keep = 4'h7;
      rel == 18'sd2: keep = 4'h3;
      default:       keep = 4'h1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (bus.valid_i)
          state_nx = (hdr_drop || hdr_short) ? DONE : PAYLOAD;
      PAYLOAD:
        if (bus.valid_i && words_left == 16'd1)
          state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.pkt_done_o = (state == DONE);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      words_left      <= '0;
      off             <= '0;
      wc              <= '0;
      lp_en           <= 1'b0;
      bus.sp_valid_o  <= 1'b0;
      bus.sp_vc_o     <= '0;
      bus.sp_dt_o     <= '0;
      bus.sp_data_o   <= '0;
      bus.lp_vc_o     <= '0;
      bus.lp_dt_o     <= '0;
      bus.tdata_o     <= '0;
      bus.tvalid_o    <= 1'b0;
      bus.tkeep_o     <= '0;
      bus.tlast_o     <= 1'b0;
      bus.ecc_err_o   <= 1'b0;
    end else begin
      bus.sp_valid_o <= 1'b0;
      bus.tvalid_o   <= 1'b0;
      bus.tlast_o    <= 1'b0;
      bus.ecc_err_o  <= 1'b0;
      if (hdr_go) begin
        if (hdr_drop) begin
          bus.ecc_err_o <= 1'b1;
        end else if (hdr_short) begin
          if (hdr_en) begin
            bus.sp_valid_o <= 1'b1;
            bus.sp_vc_o    <= hdr_vc;
            bus.sp_dt_o    <= hdr_dt;
            bus.sp_data_o  <= hdr_wc;
          end
        end else begin
          bus.lp_vc_o <= hdr_vc;
          bus.lp_dt_o <= hdr_dt;
          wc          <= hdr_wc;
          lp_en       <= hdr_en;
          off         <= '0;
          words_left  <= hdr_words[15:0];
        end
      end
      if (pay_go) begin
        words_left <= words_left - 16'd1;
        off        <= off + 17'd4;
        if (pay && lp_en) begin
          bus.tvalid_o <= 1'b1;
          bus.tdata_o  <= bus.data_i;
          bus.tkeep_o  <= keep;
          bus.tlast_o  <= last;
        end
      end
    end
  end

  assign bus.lp_wc_o = wc;

`ifdef CSI2_CRC_CHECK_EN
  logic [15:0] crc, crc_nx;
  logic [15:0] rx, rx_nx;
  logic        crc_err;

  function automatic logic [15:0] fold(
    input logic [15:0] c,
    input logic [7:0]  b
  );
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    return r;
  endfunction

  // payload bytes fold in; the two bytes after them are the CRC
  always_comb begin
    crc_nx = crc;
    rx_nx  = rx;
    for (int j = 0; j < 4; j++) begin
      if (rel > 18'(j))
        crc_nx = fold(crc_nx, bus.data_i[8*j +: 8]);
      else if (rel == 18'(j))
        rx_nx[7:0] = bus.data_i[8*j +: 8];
      else if (rel == 18'(j - 1))
        rx_nx[15:8] = bus.data_i[8*j +: 8];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      crc     <= 16'hFFFF;
      rx      <= '0;
      crc_err <= 1'b0;
    end else begin
      crc_err <= 1'b0;
      if (hdr_go) begin
        crc <= 16'hFFFF;
        rx  <= '0;
      end
      if (pay_go) begin
        crc     <= crc_nx;
        rx      <= rx_nx;
        crc_err <= (words_left == 16'd1) && (crc_nx != rx_nx);
      end
    end
  end

  assign bus.crc_err_o = crc_err;
`else
  assign bus.crc_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_csi2_pkt_handler.sv
// Scoreboard bench for csi2_pkt_handler: a packet-level model pushes
// expected output cycles, a monitor pops and compares them.
module tb_csi2_pkt_handler;
  localparam logic [3:0] MASK = 4'hD;

  typedef struct {
    bit          tv;
    logic [31:0] td;
    logic [3:0]  tk;
    bit          tl;
    bit          sv;
    logic [1:0]  svc;
    logic [5:0]  sdt;
    logic [15:0] sd;
    bit          ecc;
    bit          done;
    bit          crc;
    logic [1:0]  lvc;
    logic [5:0]  ldt;
    logic [15:0] lwc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  exp_t sbq[$];
  logic [1:0]  cur_vc;
  logic [5:0]  cur_dt;
  logic [15:0] cur_wc;

  csi2_pkt_handler_if vif();

  csi2_pkt_handler #(.VC_MASK(MASK), .PASS_CORR(1'b1)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_byte(input logic [15:0] c,
                                           input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ 16'h8408;
      else             r = r >> 1;
    end
    return r;
  endfunction

  function automatic exp_t blank();
    exp_t e;
    e = '{default: '0};
    e.lvc = cur_vc;
    e.ldt = cur_dt;
    e.lwc = cur_wc;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (vif.tvalid_o || vif.sp_valid_o || vif.ecc_err_o
        || vif.pkt_done_o || vif.crc_err_o) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got tv=%0b sp=%0b ecc=%0b done=%0b expected none",
                 vif.tvalid_o, vif.sp_valid_o, vif.ecc_err_o, vif.pkt_done_o);
      end else begin
        e = sbq.pop_front();
        chk("pkt_done", 32'(vif.pkt_done_o), 32'(e.done));
        chk("ecc_err", 32'(vif.ecc_err_o), 32'(e.ecc));
        chk("crc_err", 32'(vif.crc_err_o), 32'(e.crc));
        chk("tvalid", 32'(vif.tvalid_o), 32'(e.tv));
        chk("tlast", 32'(vif.tlast_o), 32'(e.tl));
        if (e.tv) begin
          chk("tdata", vif.tdata_o, e.td);
          chk("tkeep", 32'(vif.tkeep_o), 32'(e.tk));
        end
        chk("sp_valid", 32'(vif.sp_valid_o), 32'(e.sv));
        if (e.sv)
          chk("sp_fields", 32'({vif.sp_vc_o, vif.sp_dt_o, vif.sp_data_o}),
              32'({e.svc, e.sdt, e.sd}));
        chk("lp_fields", 32'({vif.lp_vc_o, vif.lp_dt_o, vif.lp_wc_o}),
            32'({e.lvc, e.ldt, e.lwc}));
      end
    end
  end

  task automatic drive(input logic [31:0] d, input logic v,
                       input logic e, input logic c);
    vif.data_i            = d;
    vif.valid_i           = v;
    vif.error_i           = e;
    vif.error_corrected_i = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive($urandom, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, 32'({vif.pkt_done_o, vif.sp_valid_o, vif.tvalid_o,
        vif.tlast_o, vif.ecc_err_o, vif.crc_err_o}), 32'd0);
    chk({tag, "_tdata"}, vif.tdata_o, 32'd0);
    chk({tag, "_tkeep"}, 32'(vif.tkeep_o), 32'd0);
    chk({tag, "_sp"}, 32'({vif.sp_vc_o, vif.sp_dt_o, vif.sp_data_o}), 32'd0);
    chk({tag, "_lp"}, 32'({vif.lp_vc_o, vif.lp_dt_o, vif.lp_wc_o}), 32'd0);
  endtask

  // One whole packet; gap_n idle cycles are inserted before word gap_k.
  task automatic send_pkt(input logic [1:0] vc, input logic [5:0] dt,
                          input logic [15:0] wc, input bit err,
                          input bit corr, input bit bad_crc,
                          input bit rnd_gap, input int gap_k,
                          input int gap_n, input logic [7:0] top);
    exp_t        e;
    logic [7:0]  b[$];
    logic [15:0] crc;
    logic [31:0] w;
    int          n;
    int          rem;
    bit          en;
    en = MASK[vc];
    if (err && !corr) begin
      e = blank();
      e.ecc = 1'b1;
      e.done = 1'b1;
      sbq.push_back(e);
      drive({top, wc, vc, dt}, 1'b1, err, corr);
    end else if (dt < 6'h10) begin
      e = blank();
      e.sv = en;
      e.svc = vc;
      e.sdt = dt;
      e.sd = wc;
      e.done = 1'b1;
      sbq.push_back(e);
      drive({top, wc, vc, dt}, 1'b1, err, corr);
    end else begin
      cur_vc = vc;
      cur_dt = dt;
      cur_wc = wc;
      crc = 16'hFFFF;
      for (int i = 0; i < int'(wc); i++) begin
        b.push_back(8'($urandom));
        crc = crc_byte(crc, b[i]);
      end
      if (bad_crc) crc[0] = ~crc[0];
      b.push_back(crc[7:0]);
      b.push_back(crc[15:8]);
      while (b.size() % 4 != 0) b.push_back(8'($urandom));
      n = (int'(wc) + 5) / 4;
      drive({top, wc, vc, dt}, 1'b1, err, corr);
      for (int k = 0; k < n; k++) begin
        if (k == gap_k) idle(gap_n);
        if (rnd_gap && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        w = {b[4*k+3], b[4*k+2], b[4*k+1], b[4*k]};
        e = blank();
        rem = int'(wc) - 4 * k;
        if (en && rem > 0) begin
          e.tv = 1'b1;
          e.td = w;
          e.tk = (rem >= 4) ? 4'hF : 4'((1 << rem) - 1);
          e.tl = (rem <= 4);
        end
        if (k == n - 1) begin
          e.done = 1'b1;
`ifdef CSI2_CRC_CHECK_EN
          e.crc = bad_crc;
`endif
        end
        if (e.tv || e.done) sbq.push_back(e);
        drive(w, 1'b1, 1'($urandom), 1'($urandom));
      end
    end
    // the DONE cycle ignores valid_i, so junk there must vanish
    drive($urandom, 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  initial begin
    exp_t e;
    logic [15:0] wc;
    logic [5:0]  dt;
    n_cmp = 0;
    n_bad = 0;
    cur_vc = '0;
    cur_dt = '0;
    cur_wc = '0;
    rst_n = 1'b0;
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    idle(2);
    @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    idle(1);

    send_pkt(2'd0, 6'h00, 16'h0001, 0, 0, 0, 0, -1, 0, 8'h00);
    idle(1);
    send_pkt(2'd0, 6'h2A, 16'd6, 0, 0, 0, 0, -1, 0, 8'h00);
    idle(1);
    send_pkt(2'd0, 6'h2A, 16'd4, 0, 0, 0, 0, -1, 0, 8'h00);
    idle(1);
    send_pkt(2'd2, 6'h2B, 16'd7, 0, 0, 0, 0, 1, 3, 8'h5A);
    idle(1);
    send_pkt(2'd3, 6'h01, 16'h1234, 1, 0, 0, 0, -1, 0, 8'hFF);
    idle(1);
    send_pkt(2'd3, 6'h24, 16'd5, 1, 1, 0, 0, -1, 0, 8'h00);
    idle(1);
    send_pkt(2'd1, 6'h2A, 16'd8, 0, 0, 0, 0, -1, 0, 8'h00);
    idle(1);
    send_pkt(2'd0, 6'h30, 16'd0, 0, 0, 0, 0, -1, 0, 8'h00);
    idle(1);
    send_pkt(2'd0, 6'h2A, 16'd7, 0, 0, 1, 0, -1, 0, 8'h00);
    idle(1);
    send_pkt(2'd2, 6'h2A, 16'd7, 0, 0, 0, 0, -1, 0, 8'h00);
    idle(1);

    cur_vc = 2'd0;
    cur_dt = 6'h2A;
    cur_wc = 16'd16;
    drive({8'h00, 16'd16, 2'd0, 6'h2A}, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      e = blank();
      e.tv = 1'b1;
      e.td = 32'(k * 32'h11111111 + 32'h03020100);
      e.tk = 4'hF;
      sbq.push_back(e);
      drive(e.td, 1'b1, 1'b0, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b0;
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_zero("midrst");
    rst_n = 1'b1;
    cur_vc = '0;
    cur_dt = '0;
    cur_wc = '0;
    idle(1);
    send_pkt(2'd2, 6'h02, 16'h00AB, 0, 0, 0, 0, -1, 0, 8'h00);
    idle(1);

    for (int p = 0; p < 200; p++) begin
      wc = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(0, 300))
                                       : 16'($urandom_range(0, 40));
      dt = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 15))
                                       : 6'($urandom_range(16, 63));
      send_pkt(2'($urandom), dt, wc, ($urandom_range(0, 9) == 0),
               1'($urandom), 0, 1, -1, 0, 8'($urandom));
      idle($urandom_range(0, 2));
    end

    idle(4);
    chk("sb_drain", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
